// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: mode encodings and one-hot helper shared by the
// scan decoder and its dwell tick generator.
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_STEP   = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

   // Widest select the helper supports; callers truncate the result
   // to their own 2**SEL_W width.
   localparam int MAX_SEL_W = 8;
   localparam int MAX_OUT_W = 1 << MAX_SEL_W;

   // Active-low one-hot: every bit high except bit sel.
   function automatic logic [MAX_OUT_W-1:0] onehot_n(
      input logic [MAX_SEL_W-1:0] sel
   );
      logic [MAX_OUT_W-1:0] v;
      v      = '1;
      v[sel] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: dwell counter 0..DWELL-1 with a terminal-count tick.
// Ports: clk, rst_n, clr (sync clear), en (count), tick (terminal count).
module scan_tick_gen
   import scan_decoder_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] TC = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick  = en && (cnt_q == TC);
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered active-low one-hot decoder with DIRECT, SCAN,
// STEP and HOLD index sources.
// Ports: clk, rst_n, enable_n, mode[1:0], din, step -> dout, idx, wrap.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W = 4,
   parameter int DWELL = 4,
   parameter int LAST  = (1 << SEL_W) - 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable_n,
   input  logic [1:0]              mode,
   input  logic [SEL_W-1:0]        din,
   input  logic                    step,
   output logic [(1<<SEL_W)-1:0]   dout,
   output logic [SEL_W-1:0]        idx,
   output logic                    wrap
);

   localparam int OUT_W = 1 << SEL_W;
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST);

   if (LAST >= OUT_W || LAST < 0) begin : g_bad_last
      $error("scan_decoder: LAST out of range");
   end
   if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
      $error("scan_decoder: DWELL out of range");
   end
   if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel
      $error("scan_decoder: SEL_W out of range");
   end

   mode_e            mode_s;
   mode_e            mode_q;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [OUT_W-1:0] dout_q, dout_d;
   logic             wrap_q, wrap_d;
   logic             mode_chg;
   logic             run;
   logic             tick;
   logic             adv;
   logic             dw_clr;
   logic             dw_en;

   assign mode_s   = mode_e'(mode);
   assign mode_chg = (mode_s != mode_q);
   assign run      = !enable_n;

   // Dwell clears on any mode change even while disabled; it only
   // counts in SCAN once the mode has settled.
   assign dw_clr = mode_chg
                || (mode_s == MODE_DIRECT)
                || (mode_s == MODE_STEP);
   assign dw_en  = run && !mode_chg && (mode_s == MODE_SCAN);

   scan_tick_gen #(
      .DWELL (DWELL)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (dw_clr),
      .en    (dw_en),
      .tick  (tick)
   );

   always_comb begin
      idx_d  = idx_q;
      wrap_d = 1'b0;
      adv    = 1'b0;
      if (run) begin
         unique case (1'b1)
            mode_s == MODE_DIRECT: idx_d = din;
            mode_s == MODE_SCAN:   adv   = tick;
            mode_s == MODE_STEP:   adv   = step && !mode_chg;
            mode_s == MODE_HOLD:   adv   = 1'b0;
         endcase
         if (adv) begin
            if (idx_q == LAST_IDX) begin
               idx_d  = '0;
               wrap_d = 1'b1;
            end else if (idx_q > LAST_IDX) begin
               // Leftover from DIRECT: fold back silently.
               idx_d = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      end
      dout_d = run ? OUT_W'(onehot_n(MAX_SEL_W'(idx_d))) : '1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_DIRECT;
         idx_q  <= '0;
         dout_q <= '1;
         wrap_q <= 1'b0;
      end else begin
         mode_q <= mode_s;
         idx_q  <= idx_d;
         dout_q <= dout_d;
         wrap_q <= wrap_d;
      end
   end

   assign dout = dout_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: three decoder instances (LAST 15, LAST 9, DWELL 1)
// driven in parallel and checked against a behavioural index model.
module tb_scan_decoder;

   localparam int NDUT = 3;

   logic       clk;
   logic       rst_n;
   logic       enable_n;
   logic [1:0] mode;
   logic [3:0] din;
   logic       step;

   logic [15:0] dout_o [NDUT];
   logic [3:0]  idx_o  [NDUT];
   logic        wrap_o [NDUT];

   int n_cmp = 0;
   int n_bad = 0;

   scan_decoder #(.SEL_W(4), .DWELL(4), .LAST(15)) u_a (
      .clk(clk), .rst_n(rst_n), .enable_n(enable_n), .mode(mode),
      .din(din), .step(step),
      .dout(dout_o[0]), .idx(idx_o[0]), .wrap(wrap_o[0])
   );

   scan_decoder #(.SEL_W(4), .DWELL(4), .LAST(9)) u_b (
      .clk(clk), .rst_n(rst_n), .enable_n(enable_n), .mode(mode),
      .din(din), .step(step),
      .dout(dout_o[1]), .idx(idx_o[1]), .wrap(wrap_o[1])
   );

   scan_decoder #(.SEL_W(4), .DWELL(1), .LAST(15)) u_c (
      .clk(clk), .rst_n(rst_n), .enable_n(enable_n), .mode(mode),
      .din(din), .step(step),
      .dout(dout_o[2]), .idx(idx_o[2]), .wrap(wrap_o[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout want finish");
      $fatal(1);
   end

   function automatic int last_of(input int k);
      return (k == 1) ? 9 : 15;
   endfunction

   function automatic int dwell_of(input int k);
      return (k == 2) ? 1 : 4;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Model: index per instance, edges elapsed on the current index,
   // outputs-off flag and the wrap pulse.
   int         m_idx  [NDUT];
   int         m_held [NDUT];
   bit         m_wrap [NDUT];
   bit         m_off  [NDUT];
   logic [1:0] m_pmode;

   task automatic model_edge();
      bit chg;
      bit adv;
      chg = rst_n && (mode != m_pmode);
      for (int k = 0; k < NDUT; k++) begin
         if (!rst_n) begin
            m_idx[k]  = 0;
            m_held[k] = 0;
            m_wrap[k] = 0;
            m_off[k]  = 1;
         end else begin
            adv       = 0;
            m_wrap[k] = 0;
            if (chg) m_held[k] = 0;
            m_off[k] = enable_n;
            if (!enable_n) begin
               if (mode == 2'b00) begin
                  m_idx[k] = int'(din);
               end else if (mode == 2'b01 && !chg) begin
                  m_held[k]++;
                  if (m_held[k] == dwell_of(k)) begin
                     m_held[k] = 0;
                     adv       = 1;
                  end
               end else if (mode == 2'b10 && !chg && step) begin
                  adv = 1;
               end
               if (adv) begin
                  if (m_idx[k] == last_of(k)) begin
                     m_idx[k]  = 0;
                     m_wrap[k] = 1;
                  end else if (m_idx[k] > last_of(k)) begin
                     m_idx[k] = 0;
                  end else begin
                     m_idx[k]++;
                  end
               end
            end
         end
      end
      m_pmode = rst_n ? mode : 2'b00;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         model_edge();
      end
   end

   initial begin
      logic [15:0] exp_dout;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) begin
            exp_dout = m_off[k] ? 16'hFFFF : ~(16'h1 << m_idx[k]);
            chk($sformatf("mdl_dout%0d", k), 32'(dout_o[k]), 32'(exp_dout));
            chk($sformatf("mdl_idx%0d", k), 32'(idx_o[k]), 32'(m_idx[k]));
            chk($sformatf("mdl_wrap%0d", k), 32'(wrap_o[k]), 32'(m_wrap[k]));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int nw;
      int wat;
      int held;
      bit found;
      bit done;

      rst_n    = 1'b1;
      enable_n = 1'b0;
      mode     = 2'b00;
      din      = 4'd0;
      step     = 1'b0;
      #1 rst_n = 1'b0;
      cyc(3);
      chk("rst_dout", 32'(dout_o[0]), 32'hFFFF);
      chk("rst_idx", 32'(idx_o[0]), 32'd0);
      chk("rst_wrap", 32'(wrap_o[0]), 32'd0);

      // DIRECT decode, one-edge latency
      rst_n = 1'b1;
      din   = 4'd5;
      cyc(1);
      chk("dir5_idx", 32'(idx_o[0]), 32'd5);
      chk("dir5_dout", 32'(dout_o[0]), 32'hFFDF);
      din = 4'd15;
      cyc(1);
      chk("dir15_dout_a", 32'(dout_o[0]), 32'h7FFF);
      chk("dir15_dout_b", 32'(dout_o[1]), 32'h7FFF);

      // DIRECT above LAST then SCAN folds to 0 without wrap
      din = 4'd12;
      cyc(1);
      mode = 2'b01;
      cyc(1);
      chk("scan_entry_b", 32'(idx_o[1]), 32'd12);
      cyc(4);
      chk("fold_idx_b", 32'(idx_o[1]), 32'd0);
      chk("fold_wrap_b", 32'(wrap_o[1]), 32'd0);
      chk("fold_idx_a", 32'(idx_o[0]), 32'd13);

      // SCAN from reset: 4-cycle dwell, wrap after 64 cycles
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      nw  = 0;
      wat = -1;
      for (int c = 0; c < 70; c++) begin
         cyc(1);
         if (c == 3) chk("scan_hold3", 32'(idx_o[0]), 32'd0);
         if (c == 4) begin
            chk("scan_adv4", 32'(idx_o[0]), 32'd1);
            chk("dwell1_c4", 32'(idx_o[2]), 32'd4);
         end
         if (wrap_o[0]) begin
            nw++;
            wat = c;
         end
      end
      chk("wrap_at", 32'(wat), 32'd64);
      chk("wrap_cnt", 32'(nw), 32'd1);

      // Asynchronous reset mid-scan at idx 7
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         cyc(1);
         if (idx_o[0] == 4'd7) found = 1;
      end
      chk("wait_idx7", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_dout", 32'(dout_o[0]), 32'hFFFF);
      chk("async_idx", 32'(idx_o[0]), 32'd0);
      chk("async_wrap", 32'(wrap_o[0]), 32'd0);
      cyc(2);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cyc(1);
         if (c == 3) chk("restart_hold", 32'(idx_o[0]), 32'd0);
         if (c == 4) chk("restart_adv", 32'(idx_o[0]), 32'd1);
      end

      // enable_n high mid-dwell at idx 3 on LAST=9
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         cyc(1);
         if (idx_o[1] == 4'd3) found = 1;
      end
      chk("wait_b3", 32'(found), 32'd1);
      cyc(1);
      held     = 2;
      enable_n = 1'b1;
      cyc(3);
      chk("dis_dout", 32'(dout_o[1]), 32'hFFFF);
      chk("dis_idx", 32'(idx_o[1]), 32'd3);
      enable_n = 1'b0;
      done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         cyc(1);
         if (idx_o[1] == 4'd3 && dout_o[1] != 16'hFFFF) held++;
         else done = 1;
      end
      chk("resume_hold", 32'(held), 32'd4);

      // Mode change together with enable_n rising
      mode     = 2'b11;
      enable_n = 1'b1;
      cyc(2);
      mode     = 2'b01;
      enable_n = 1'b0;
      cyc(6);

      // STEP across LAST=9
      mode = 2'b00;
      din  = 4'd8;
      cyc(1);
      chk("step_pre", 32'(idx_o[1]), 32'd8);
      mode = 2'b10;
      step = 1'b0;
      cyc(1);
      step = 1'b1;
      cyc(1);
      chk("step1_idx", 32'(idx_o[1]), 32'd9);
      chk("step1_wrap", 32'(wrap_o[1]), 32'd0);
      cyc(1);
      chk("step2_idx", 32'(idx_o[1]), 32'd0);
      chk("step2_wrap", 32'(wrap_o[1]), 32'd1);
      cyc(1);
      chk("step3_idx", 32'(idx_o[1]), 32'd1);
      chk("step3_wrap", 32'(wrap_o[1]), 32'd0);
      step = 1'b0;
      cyc(2);
      chk("step_hold", 32'(idx_o[1]), 32'd1);

      // STEP from above LAST folds without wrap
      mode = 2'b00;
      din  = 4'd12;
      cyc(1);
      mode = 2'b10;
      cyc(1);
      step = 1'b1;
      cyc(1);
      chk("stepfold_idx", 32'(idx_o[1]), 32'd0);
      chk("stepfold_wrap", 32'(wrap_o[1]), 32'd0);
      step = 1'b0;

      // DIRECT while disabled does not load
      enable_n = 1'b1;
      mode     = 2'b00;
      din      = 4'd3;
      cyc(2);
      enable_n = 1'b0;
      cyc(2);
      chk("dir_resume", 32'(idx_o[0]), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
